// File: rtl/nibble_adder_sched_if.sv
// Bus bundle between nibble_adder_sched, its requesters/consumer and the shared 4-bit adder.
interface nibble_adder_sched_if #(
    parameter int NREQ = 4,
    parameter int NIB  = 4
);
    localparam int WIDTH = 4 * NIB;
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic [3:0]            add_a;
    logic [3:0]            add_b;
    logic                  add_cin;
    logic [3:0]            add_sum;
    logic                  add_cout;

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, add_sum, add_cout,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, add_a, add_b, add_cin
    );

    // Requesters, result consumer and shared adder side.
    modport master (
        output req_valid, req_a, req_b, rsp_ready, add_sum, add_cout,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, add_a, add_b, add_cin
    );
endinterface

// File: rtl/nibble_adder_sched.sv
// Round-robin scheduler time-sharing one external 4-bit adder; WIDTH-bit adds are
// sequenced LSB nibble first with the carry chained through a register.
module nibble_adder_sched #(
    parameter int NREQ = 4,
    parameter int NIB  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_adder_sched_if.slave  bus
);
    localparam int WIDTH = 4 * NIB;
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int KW    = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [KW-1:0]   K_LAST  = KW'(NIB - 1);
    localparam logic [IDW-1:0]  ID_LAST = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [IDW-1:0]   rr_ptr_r;
    logic [IDW-1:0]   id_r;
    logic [KW-1:0]    k_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             rsp_valid_r;
    logic             rsp_cout_r;

    logic             gnt_any_s;
    logic [IDW-1:0]   gnt_idx_s;
    logic [IDW-1:0]   scan_idx_s;
    logic [IDW-1:0]   rr_next_s;
    logic [WIDTH-1:0] gnt_a_s;
    logic [WIDTH-1:0] gnt_b_s;

    // Round-robin pick: scanning offsets high to low lets the nearest valid index at or after rr_ptr win.
    always_comb begin
        gnt_any_s  = |bus.req_valid;
        gnt_idx_s  = '0;
        scan_idx_s = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            scan_idx_s = IDW'((int'(rr_ptr_r) + j) % NREQ);
            gnt_idx_s  = bus.req_valid[scan_idx_s] ? scan_idx_s : gnt_idx_s;
        end
    end

    // Operand slices and next pointer for the requester being granted.
    always_comb begin
        gnt_a_s   = bus.req_a[gnt_idx_s*WIDTH +: WIDTH];
        gnt_b_s   = bus.req_b[gnt_idx_s*WIDTH +: WIDTH];
        rr_next_s = (gnt_idx_s == ID_LAST) ? '0 : gnt_idx_s + IDW'(1);
    end

    // Accept pulse is only ever raised while idle.
    always_comb begin
        bus.req_ready = '0;
        if ((state_r == IDLE) && gnt_any_s) begin
            bus.req_ready = ONE_HOT << gnt_idx_s;
        end else begin
            bus.req_ready = '0;
        end
    end

    // Shared adder operands: current nibble while running, quiet zeros otherwise.
    always_comb begin
        bus.add_a   = 4'h0;
        bus.add_b   = 4'h0;
        bus.add_cin = 1'b0;
        if (state_r == RUN) begin
            bus.add_a   = a_r[k_r*4 +: 4];
            bus.add_b   = b_r[k_r*4 +: 4];
            bus.add_cin = carry_r;
        end else begin
            bus.add_cin = 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = id_r;
    assign bus.rsp_sum   = sum_r;
    assign bus.rsp_cout  = rsp_cout_r;

    // Scheduler FSM: grant, nibble-serial add, hold result until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            id_r        <= '0;
            k_r         <= '0;
            carry_r     <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            rsp_valid_r <= 1'b0;
            rsp_cout_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (gnt_any_s) begin
                        a_r      <= gnt_a_s;
                        b_r      <= gnt_b_s;
                        id_r     <= gnt_idx_s;
                        rr_ptr_r <= rr_next_s;
                        k_r      <= '0;
                        carry_r  <= 1'b0;
                        state_r  <= RUN;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    sum_r[k_r*4 +: 4] <= bus.add_sum;
                    carry_r           <= bus.add_cout;
                    if (k_r == K_LAST) begin
                        k_r         <= '0;
                        rsp_cout_r  <= bus.add_cout;
                        rsp_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        k_r         <= k_r + KW'(1);
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_adder_sched.sv
// Randomized scoreboard bench for nibble_adder_sched with a behavioural adder and arbiter model.
module tb_nibble_adder_sched;
    localparam int NREQ  = 4;
    localparam int NIB   = 4;
    localparam int WIDTH = 4 * NIB;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   sum;
    } op_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    nibble_adder_sched_if #(.NREQ(NREQ), .NIB(NIB)) bus ();

    nibble_adder_sched #(.NREQ(NREQ), .NIB(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // The shared external adder.
    assign {bus.add_cout, bus.add_sum} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;
    int n_rsp  = 0;

    logic [NREQ-1:0]  v_drv;
    logic [WIDTH-1:0] a_drv [NREQ];
    logic [WIDTH-1:0] b_drv [NREQ];
    logic             rdy_drv;
    bit               refresh   = 1'b0;
    bit               rand_mode = 1'b0;
    bit               rmode     = 1'b0;
    logic [NREQ-1:0]  last_gnt  = '0;
    op_t              sbq[$];

    // Model state of the arbiter/sequencer, owned by the monitor.
    int               mrr  = 0;
    bit               busy = 1'b0;
    int               gcyc = 0;
    logic [WIDTH-1:0] last_sum  = '0;
    int               last_id   = 0;
    logic             last_cout = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            passes++;
        end
    endfunction

    task automatic drive();
        bus.req_valid = v_drv;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*WIDTH +: WIDTH] = a_drv[i];
            bus.req_b[i*WIDTH +: WIDTH] = b_drv[i];
        end
        bus.rsp_ready = rdy_drv;
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        v_drv[i] = 1'b1;
        a_drv[i] = a;
        b_drv[i] = b;
        drive();
    endtask

    // One clock: log granted ops into the scoreboard, then update stimulus.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (last_gnt[i]) begin
                op_t o;
                o.id  = i;
                o.a   = a_drv[i];
                o.b   = b_drv[i];
                o.sum = {1'b0, a_drv[i]} + {1'b0, b_drv[i]};
                sbq.push_back(o);
                if (refresh) begin
                    a_drv[i] = WIDTH'($urandom);
                    b_drv[i] = WIDTH'($urandom);
                end else begin
                    v_drv[i] = 1'b0;
                end
            end else if (rand_mode) begin
                if (!v_drv[i] && $urandom_range(0, 3) == 0) begin
                    v_drv[i] = 1'b1;
                    a_drv[i] = WIDTH'($urandom);
                    b_drv[i] = WIDTH'($urandom);
                end else if (v_drv[i] && $urandom_range(0, 15) == 0) begin
                    v_drv[i] = 1'b0;
                end
            end
        end
        if (rmode) rdy_drv = ($urandom_range(0, 3) != 0);
        drive();
    endtask

    task automatic wait_rsp(input int target);
        for (int b = 0; b < 100 && n_rsp < target; b++) tick();
        chk("rsp_count", n_rsp, target);
    endtask

    // Monitor: behavioural arbiter/adder model compared against the DUT every cycle.
    initial begin : monitor
        bit      exp_rv;
        bit      in_run;
        int      k;
        int      w;
        longint  lo;
        logic [NREQ-1:0] exp_rr;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req_ready", bus.req_ready, 0);
                chk("rst_rsp_valid", bus.rsp_valid, 0);
                chk("rst_rsp_sum",   bus.rsp_sum,   0);
                chk("rst_rsp_id",    bus.rsp_id,    0);
                chk("rst_rsp_cout",  bus.rsp_cout,  0);
                chk("rst_add_a",     bus.add_a,     0);
                chk("rst_add_b",     bus.add_b,     0);
                chk("rst_add_cin",   bus.add_cin,   0);
                busy = 1'b0; mrr = 0; sbq.delete();
                last_sum = '0; last_id = 0; last_cout = 1'b0; last_gnt = '0;
            end else begin
                exp_rv = busy && (cyc >= gcyc + NIB + 1);
                in_run = busy && (cyc >= gcyc + 1) && (cyc <= gcyc + NIB);
                chk("rsp_valid", bus.rsp_valid, exp_rv);
                if (in_run || exp_rv) chk("sb_depth", sbq.size(), 1);
                if (in_run && sbq.size() > 0) begin
                    k  = cyc - gcyc - 1;
                    lo = (64'd1 << (4 * k)) - 64'd1;
                    chk("add_a",   bus.add_a,   (longint'(sbq[0].a) >> (4 * k)) & 64'hF);
                    chk("add_b",   bus.add_b,   (longint'(sbq[0].b) >> (4 * k)) & 64'hF);
                    chk("add_cin", bus.add_cin,
                        ((longint'(sbq[0].a) & lo) + (longint'(sbq[0].b) & lo)) >> (4 * k));
                end else begin
                    chk("add_a_idle",   bus.add_a,   0);
                    chk("add_b_idle",   bus.add_b,   0);
                    chk("add_cin_idle", bus.add_cin, 0);
                end
                if (!busy) begin
                    chk("hold_sum",  bus.rsp_sum,  last_sum);
                    chk("hold_id",   bus.rsp_id,   last_id);
                    chk("hold_cout", bus.rsp_cout, last_cout);
                end
                if (exp_rv && sbq.size() > 0) begin
                    chk("rsp_id",   bus.rsp_id,   sbq[0].id);
                    chk("rsp_sum",  bus.rsp_sum,  sbq[0].sum[WIDTH-1:0]);
                    chk("rsp_cout", bus.rsp_cout, sbq[0].sum[WIDTH]);
                end
                exp_rr = '0;
                if (!busy) begin
                    w = -1;
                    for (int j = NREQ - 1; j >= 0; j--) begin
                        if (v_drv[(mrr + j) % NREQ]) w = (mrr + j) % NREQ;
                    end
                    if (w >= 0) exp_rr[w] = 1'b1;
                    chk("req_ready_grant", bus.req_ready, exp_rr);
                    if (w >= 0) begin
                        busy = 1'b1;
                        gcyc = cyc;
                        mrr  = (w + 1) % NREQ;
                    end
                end else begin
                    chk("req_ready_busy", bus.req_ready, 0);
                end
                if (exp_rv && rdy_drv && sbq.size() > 0) begin
                    last_sum  = sbq[0].sum[WIDTH-1:0];
                    last_cout = sbq[0].sum[WIDTH];
                    last_id   = sbq[0].id;
                    void'(sbq.pop_front());
                    busy  = 1'b0;
                    n_rsp = n_rsp + 1;
                end
                last_gnt = exp_rr;
            end
        end
    end

    initial begin : stim
        int exp_n;
        exp_n   = 0;
        v_drv   = '0;
        rdy_drv = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            a_drv[i] = '0;
            b_drv[i] = '0;
        end
        drive();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Plain add, then full carry ripple, on requester 0.
        set_req(0, 16'h1234, 16'h4321);
        exp_n++; wait_rsp(exp_n);
        set_req(0, 16'hFFFF, 16'h0001);
        exp_n++; wait_rsp(exp_n);

        // All requesters continuously valid.
        refresh = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'($urandom), WIDTH'($urandom));
        exp_n += 5; wait_rsp(exp_n);
        refresh = 1'b0;
        v_drv = '0;
        drive();
        tick();

        // Consumer stalls in DONE while another requester waits.
        rdy_drv = 1'b0;
        set_req(1, 16'hA5A5, 16'h5A5B);
        tick();
        set_req(2, 16'h0F0F, 16'hF0F1);
        repeat (7) tick();
        rdy_drv = 1'b1;
        drive();
        exp_n += 2; wait_rsp(exp_n);
        tick();

        // Reset during the third RUN nibble drops the op and rewinds the pointer.
        set_req(0, 16'h7777, 16'h1111);
        repeat (3) tick();
        rst_n = 1'b0;
        v_drv = '0;
        drive();
        repeat (2) tick();
        rst_n = 1'b1;
        set_req(1, 16'h0102, 16'h0304);
        set_req(3, 16'hFFF0, 16'h0020);
        exp_n += 2; wait_rsp(exp_n);
        tick();

        // Top requester with MSB overflow, then pointer wrap to 0.
        set_req(3, 16'h8000, 16'h8000);
        exp_n++; wait_rsp(exp_n);
        set_req(0, WIDTH'($urandom), WIDTH'($urandom));
        set_req(2, WIDTH'($urandom), WIDTH'($urandom));
        exp_n += 2; wait_rsp(exp_n);

        // Random traffic with random consumer backpressure.
        rand_mode = 1'b1;
        rmode     = 1'b1;
        repeat (600) tick();
        rand_mode = 1'b0;
        rmode     = 1'b0;
        rdy_drv   = 1'b1;
        v_drv     = '0;
        drive();
        for (int b = 0; b < 40 && busy; b++) tick();
        chk("drain_idle", busy, 0);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
